seq_det_ctrl: RTL and testbench
===============================

// Module: seq_det_ctrl
// PURPOSE
//  Controller that streams parallel words, MSB-first, into a Moore 1011 overlapping sequence detector.
//  Counts detections across a multi-word frame and returns the frame count on a valid/ready output.
//  Sits between a word-wide producer and the serial detector, which it sequences (enable, clear, flush).
// PARAMETERS
//  W        8        data word width; bits shifted per accepted word
//  CW       8        width of the match counter; saturates at 2**CW-1
//  PATTERN  4'b1011  pattern loaded into the detector; MSB is the first bit in time
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous active-high reset
//  in_valid   in   1   producer word valid
//  in_ready   out  1   controller can accept a word; high only in IDLE and while rst=0
//  in_data    in   W   word, serialized bit W-1 first
//  in_last    in   1   word is the last of the frame; sampled with the word
//  out_valid  out  1   frame count available
//  out_ready  in   1   consumer accepts the count
//  out_count  out  CW  matches in the frame; stable while out_valid=1
//  det_pulse  out  1   one-cycle pulse per counted match
//  busy       out  1   frame in progress: first word accepted, count not yet consumed
// BEHAVIOUR
//  Reset: state=IDLE; detector state=S0; count=0; out_valid=0; det_pulse=0; busy=0; in_ready=0 while rst=1.
//  States:
//   - IDLE -> SHIFT when in_valid&in_ready; latches in_data and in_last; bit index=W-1.
//   - SHIFT: for W cycles, drive detector din=word[idx], bit_en=1, idx--.
//     After idx 0: to FLUSH if last, else to IDLE.
//   - FLUSH: one cycle with bit_en=0, so the Moore output for the final bit is counted. Then DONE.
//   - DONE: out_valid=1. On out_ready, to IDLE; det_clr=1 (detector to S0) and count=0 on that edge.
//  Detector advances only on bit_en=1 and holds state otherwise. Matches span word boundaries within a frame.
//  Moore timing: bit presented in cycle k completes the pattern -> detector y=1 in cycle k+1.
//  Count rule: adv_d is bit_en delayed one cycle.
//   - If adv_d&y: count++ (saturating) and det_pulse=1 in that same cycle. This is state-independent, so it also fires in IDLE/FLUSH.
//  Throughput: non-last words every W+1 cycles with in_valid held high. Last word W+2 cycles to out_valid.
//  Latency: last-word accept at edge T -> out_valid=1 from cycle T+W+2.
//  in_valid low mid-frame: detector holds state indefinitely; no timeout.
//  out_ready held low: DONE persists, out_count stable, in_ready=0.
//  in_last is only meaningful with an accepted word. An empty frame is impossible.
//  Overlap: after a match the detector goes to the state for suffix "1", so 1011011 gives 2 matches.
//  Reset mid-SHIFT/FLUSH/DONE: next cycle is IDLE with count=0 and detector=S0; the partial frame is discarded.
//  Arithmetic: count is unsigned CW bits; it holds at all-ones after saturation. idx is $clog2(W) bits.
// STRUCTURE
//  Package seq_det_pkg: state enum {IDLE,SHIFT,FLUSH,DONE} and the detector state enum S0..S4.
//  Sub-module seq_det_moore: parameter PATTERN; ports clk, rst, clr, en, din, y.
//   - Moore FSM with overlapping match; y decoded from registered state only.
//  Controller holds the FSM, word shift register, idx, adv_d, and counter.
// TESTING (W=8, CW=8 unless noted)
//  1 Single word 8'b1011_0110, last=1 -> out_count=2; det_pulse in cycles T+5 and T+8; out_valid at T+10.
//  2 Cross-boundary frame: 8'b0000_0101 last=0, then 8'b1000_0000 last=1 -> out_count=1.
//  3 8'hFF last=1 -> 0. Then 8'hBB last=1 -> 2 (detector cleared between frames, no carry-over).
//  4 CW=2: frame of three 8'hBB words -> six matches counted, out_count=3 (saturated).
//  5 out_ready low 20 cycles in DONE -> out_valid, out_count stable; in_ready=0. Release -> IDLE next cycle.
//  6 rst pulsed at 4th SHIFT cycle -> in_ready=1 one cycle after release. Next frame 8'hB0 last=1 -> out_count=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the serial 1011 detector and its word-streaming controller.
package seq_det_pkg;

  // Controller phases: wait for a word, shift it out, flush the last Moore output, hold the result.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } ctrl_state_t;

  // Detector states: S<k> means the last k bits seen equal the first k pattern bits.
  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

  localparam int PLEN = 4;

  // Next detector state for an arbitrary 4-bit pattern (MSB first in time).
  // Builds the matched prefix plus the new bit, then keeps the longest suffix
  // that is still a pattern prefix, which gives overlapping detection.
  function automatic det_state_t det_next(input logic [PLEN-1:0] pat,
                                          input det_state_t      cur,
                                          input logic            b);
    logic [PLEN:0] seq;
    int            k;
    int            best;
    int            pos;
    logic          ok;
    k   = int'(cur);
    seq = '0;
    for (int i = 0; i < PLEN; i++) begin
      if (i < k) seq[i] = pat[PLEN-1-i];
    end
    seq[k] = b;
    best = 0;
    for (int l = 1; l <= PLEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PLEN; j++) begin
          if (j < l) begin
            pos = k + 1 - l + j;
            if (seq[pos] != pat[PLEN-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return det_state_t'(best[2:0]);
  endfunction

endpackage

// File: rtl/seq_det_moore.sv
// Moore overlapping pattern detector; y is decoded from the registered state only.
module seq_det_moore
  import seq_det_pkg::*;
#(
  parameter logic [3:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic y
);

  det_state_t state;
  det_state_t state_nxt;

  // Next-state: advance on en, otherwise hold.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (en) state_nxt = det_next(PATTERN, state, din);
  end

  // State register with synchronous reset and clear back to S0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all registers sample pre-edge values together.
    if (rst || clr) state <= S0;
    else            state <= state_nxt;
  end

  assign y = (state == S4);

endmodule

// File: rtl/seq_det_ctrl.sv
// Streams accepted words MSB-first into the Moore detector and counts matches per frame.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int         W       = 8,
  parameter int         CW      = 8,
  parameter logic [3:0] PATTERN = 4'b1011
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          det_pulse,
  output logic          busy
);

  localparam int            IW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  ctrl_state_t   state;
  ctrl_state_t   state_nxt;
  logic [W-1:0]  word_q;
  logic          last_q;
  logic [IW-1:0] idx_q;
  logic          adv_d;
  logic [CW-1:0] count_q;
  logic          busy_q;
  logic          bit_en;
  logic          det_clr;
  logic          accept;
  logic          din;
  logic          y;

  // Next-state and per-state controls for the frame sequencer.
  always_comb begin
    state_nxt = state;
    bit_en    = 1'b0;
    det_clr   = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_en = 1'b1;
        if (idx_q == '0) state_nxt = last_q ? FLUSH : IDLE;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
          det_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign din       = word_q[idx_q];
  assign det_pulse = adv_d && y;
  assign out_count = count_q;
  assign busy      = busy_q;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word latch, bit index, advance delay and frame-in-progress flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
      adv_d  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      adv_d <= bit_en;
      if (accept) begin
        word_q <= in_data;
        last_q <= in_last;
        idx_q  <= IW'(W - 1);
        busy_q <= 1'b1;
      end else if (state == SHIFT && idx_q != '0) begin
        idx_q <= idx_q - IW'(1);
      end
      if (det_clr) busy_q <= 1'b0;
    end
  end

  // Saturating match counter; cleared when the consumer takes the result.
  always_ff @(posedge clk) begin
    if (rst || det_clr)                 count_q <= '0;
    else if (det_pulse && count_q != CMAX) count_q <= count_q + CW'(1);
  end

  seq_det_moore #(.PATTERN(PATTERN)) u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (bit_en),
    .din (din),
    .y   (y)
  );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: two controllers (CW=8 and CW=2) against a frame-level bitstream model.
module tb_seq_det_ctrl;

  localparam int         W   = 8;
  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, det_pulse_a, busy_a;
  logic [7:0] out_count_a;
  logic       in_ready_b, out_valid_b, det_pulse_b, busy_b;
  logic [1:0] out_count_b;

  seq_det_ctrl #(.W(8), .CW(8), .PATTERN(4'b1011)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_count(out_count_a), .det_pulse(det_pulse_a),
    .busy(busy_a)
  );

  seq_det_ctrl #(.W(8), .CW(2), .PATTERN(4'b1011)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_count(out_count_b), .det_pulse(det_pulse_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- behavioural model ----------------
  // Frame = bitstream of all accepted words; a match ends wherever the last
  // four frame bits equal the pattern. Timing is kept as cycle stamps.
  bit frame_bits[$];
  bit pulse_at[int];
  int shift_end = 0;
  int dv_from   = 0;
  bit pend_done = 1'b0;
  bit busy_m    = 1'b0;
  int frame_cnt = 0;

  always @(negedge clk) begin : monitor
    int   c, ca, n;
    logic er, eov, ep;
    c   = cyc;
    er  = !rst && (c >= shift_end) && !pend_done;
    eov = pend_done && (c >= dv_from);
    ep  = pulse_at.exists(c);
    check("in_ready_a", in_ready_a, er);
    check("in_ready_b", in_ready_b, er);
    if (!rst) begin
      check("out_valid_a", out_valid_a, eov);
      check("out_valid_b", out_valid_b, eov);
      check("det_pulse_a", det_pulse_a, ep);
      check("det_pulse_b", det_pulse_b, ep);
      check("busy_a", busy_a, busy_m);
      check("busy_b", busy_b, busy_m);
      check("out_count_a", out_count_a, sat(frame_cnt, 255));
      check("out_count_b", out_count_b, sat(frame_cnt, 3));
    end
    if (rst) begin
      frame_bits.delete();
      pulse_at.delete();
      shift_end = 0;
      pend_done = 1'b0;
      busy_m    = 1'b0;
      frame_cnt = 0;
    end else begin
      if (ep) begin
        frame_cnt++;
        pulse_at.delete(c);
      end
      if (in_valid && er) begin
        ca = c + 1;
        for (int i = 0; i < W; i++) begin
          frame_bits.push_back(in_data[W-1-i]);
          n = frame_bits.size();
          if (n >= 4 && frame_bits[n-4] == PAT[3] && frame_bits[n-3] == PAT[2] &&
              frame_bits[n-2] == PAT[1] && frame_bits[n-1] == PAT[0])
            pulse_at[ca + i + 1] = 1'b1;
        end
        shift_end = ca + W;
        busy_m    = 1'b1;
        if (in_last) begin
          pend_done = 1'b1;
          dv_from   = ca + W + 1;
        end
      end
      if (eov && out_ready) begin
        pend_done = 1'b0;
        busy_m    = 1'b0;
        frame_bits.delete();
        frame_cnt = 0;
      end
    end
  end

  // Pulse cycle log for the hand-computed timing checks.
  int pulse_log[$];
  always @(negedge clk) if (!rst && det_pulse_a) pulse_log.push_back(cyc);

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input int gap, output int ca);
    int n;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n  = 0;
    ca = -1;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready_a) break;
      n++;
    end
    step();
    check("send_timeout", n >= 200, 0);
    if (n < 200) ca = cyc;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_done(input int hold, output int dv, output logic [7:0] ca_cnt,
                           output logic [1:0] cb_cnt);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (out_valid_a) break;
      n++;
    end
    check("done_timeout", n >= 400, 0);
    dv     = cyc;
    ca_cnt = out_count_a;
    cb_cnt = out_count_b;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check("hold_out_valid", out_valid_a, 1);
      check("hold_out_count", out_count_a, ca_cnt);
      check("hold_in_ready", in_ready_a, 0);
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_in_ready", in_ready_a, 1);
    check("release_out_valid", out_valid_a, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         ca, dv, base, nw;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    repeat (2) step();
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", out_count_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    step();

    // 1: single word, two overlapping matches, exact pulse and result timing.
    base = pulse_log.size();
    send_word(8'b1011_0110, 1'b1, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t1_count", cnt_a, 2);
    check("t1_pulses", pulse_log.size() - base, 2);
    if (pulse_log.size() - base == 2) begin
      check("t1_pulse0_cycle", pulse_log[base] - ca, 4);
      check("t1_pulse1_cycle", pulse_log[base+1] - ca, 7);
    end
    check("t1_valid_cycle", dv - ca, 9);

    // 2: match across a word boundary.
    send_word(8'b0000_0101, 1'b0, 0, ca);
    send_word(8'b1000_0000, 1'b1, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t2_count", cnt_a, 1);

    // 3: no match, then a fresh frame with no carry-over.
    send_word(8'hFF, 1'b1, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t3a_count", cnt_a, 0);
    send_word(8'hBB, 1'b1, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t3b_count", cnt_a, 2);

    // 4: six matches; CW=2 saturates at 3.
    for (int k = 0; k < 3; k++) send_word(8'hBB, k == 2, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t4_count_cw8", cnt_a, 6);
    check("t4_count_cw2", cnt_b, 3);

    // 5: consumer stalls 20 cycles in DONE.
    send_word(8'b1011_0110, 1'b1, 0, ca);
    wait_done(20, dv, cnt_a, cnt_b);
    check("t5_count", cnt_a, 2);

    // 6: reset during the fourth shift cycle discards the partial frame.
    send_word(8'b1011_0110, 1'b1, 0, ca);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_in_ready", in_ready_a, 1);
    check("t6_busy", busy_a, 0);
    check("t6_count", out_count_a, 0);
    step();
    send_word(8'hB0, 1'b1, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("t6_next_count", cnt_a, 1);

    // CW=8 saturation: 130 words of 0xBB give 260 matches.
    for (int k = 0; k < 130; k++) send_word(8'hBB, k == 129, 0, ca);
    wait_done(0, dv, cnt_a, cnt_b);
    check("sat_count_cw8", cnt_a, 255);
    check("sat_count_cw2", cnt_b, 3);

    // Random frames with gaps and consumer stalls.
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++)
        send_word(($urandom_range(0, 2) == 0) ? 8'hB6 : 8'($urandom), k == nw - 1,
                  $urandom_range(0, 3), ca);
      wait_done($urandom_range(0, 4), dv, cnt_a, cnt_b);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
